// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame parser.
// The checksum byte is enabled by defining UART_FRAME_CHKSUM_EN.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHK     = 3'd3,
        ST_EMIT    = 3'd4
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_CHK  = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    localparam logic [7:0] DEFAULT_SOF = 8'hA5;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: MAX_LEN x 8 registers, one synchronous write port,
// one combinational read port. Contents are not reset.
module uart_frame_buf
    import uart_frame_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int AW      = $clog2(MAX_LEN)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [MAX_LEN];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_frame_parser.sv
// Parses SOF/LEN/payload[/CHK] frames from an RX FIFO and replays the payload
// on a valid/ready stream. Checksum byte present when UART_FRAME_CHKSUM_EN is defined.
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter int         MAX_LEN        = 16,
    parameter logic [7:0] SOF            = DEFAULT_SOF,
    parameter int         TIMEOUT_CYCLES = 100_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fifo_empty_i,
    input  logic [7:0] fifo_rd_data_i,
    output logic       fifo_rd_en_o,
    output logic [7:0] pl_data_o,
    output logic       pl_valid_o,
    output logic       pl_last_o,
    input  logic       pl_ready_i,
    output logic       err_o,
    output logic [1:0] err_code_o,
    output logic [7:0] err_cnt_o,
    output logic [2:0] dbg_state_o
);

    localparam int AW = $clog2(MAX_LEN);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

    state_t        state_q, state_d;
    logic          rd_pend_q;
    logic [7:0]    len_q, len_d;
    logic [7:0]    idx_q, idx_d;
    logic [TW-1:0] tmo_q;
    logic          active, tmo_hit, buf_we, err_det;
    logic [1:0]    err_code_d;
    logic [7:0]    buf_rdata;
    logic          byte_vld;
    logic [7:0]    rx_byte;
`ifdef UART_FRAME_CHKSUM_EN
    logic [7:0]    chk_q, chk_d;
`endif

    // A byte is present exactly one cycle after its read strobe.
    assign byte_vld = rd_pend_q;
    assign rx_byte  = fifo_rd_data_i;
    assign active   = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CHK);
    assign tmo_hit  = active && !rd_pend_q && (tmo_q == TMO_LAST);

    // FIFO handshake: strobe only with no read in flight and outside EMIT.
    assign fifo_rd_en_o = !rst && !fifo_empty_i && !rd_pend_q && (state_q != ST_EMIT);

    assign pl_valid_o  = (state_q == ST_EMIT);
    assign pl_data_o   = pl_valid_o ? buf_rdata : 8'h00;
    assign pl_last_o   = pl_valid_o && (idx_q == len_q - 8'd1);
    assign dbg_state_o = state_q;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        idx_d      = idx_q;
        buf_we     = 1'b0;
        err_det    = 1'b0;
        err_code_d = ERR_NONE;
`ifdef UART_FRAME_CHKSUM_EN
        chk_d      = chk_q;
`endif
        case (state_q)
            ST_HUNT: begin
                if (byte_vld && rx_byte == SOF) state_d = ST_LEN;
            end
            ST_LEN: begin
                if (byte_vld) begin
                    if (rx_byte == 8'd0 || rx_byte > MAX_LEN_B) begin
                        err_det    = 1'b1;
                        err_code_d = ERR_LEN;
                        state_d    = ST_HUNT;
                    end else begin
                        len_d   = rx_byte;
                        idx_d   = 8'd0;
`ifdef UART_FRAME_CHKSUM_EN
                        chk_d   = rx_byte;
`endif
                        state_d = ST_PAYLOAD;
                    end
                end else if (tmo_hit) begin
                    err_det    = 1'b1;
                    err_code_d = ERR_TMO;
                    state_d    = ST_HUNT;
                end
            end
            ST_PAYLOAD: begin
                if (byte_vld) begin
                    buf_we = 1'b1;
                    idx_d  = idx_q + 8'd1;
`ifdef UART_FRAME_CHKSUM_EN
                    chk_d  = chk_q ^ rx_byte;
                    if (idx_q == len_q - 8'd1) state_d = ST_CHK;
`else
                    if (idx_q == len_q - 8'd1) begin
                        idx_d   = 8'd0;
                        state_d = ST_EMIT;
                    end
`endif
                end else if (tmo_hit) begin
                    err_det    = 1'b1;
                    err_code_d = ERR_TMO;
                    state_d    = ST_HUNT;
                end
            end
`ifdef UART_FRAME_CHKSUM_EN
            ST_CHK: begin
                if (byte_vld) begin
                    if (rx_byte == chk_q) begin
                        idx_d   = 8'd0;
                        state_d = ST_EMIT;
                    end else begin
                        err_det    = 1'b1;
                        err_code_d = ERR_CHK;
                        state_d    = ST_HUNT;
                    end
                end else if (tmo_hit) begin
                    err_det    = 1'b1;
                    err_code_d = ERR_TMO;
                    state_d    = ST_HUNT;
                end
            end
`endif
            ST_EMIT: begin
                if (pl_ready_i) begin
                    if (idx_q == len_q - 8'd1) state_d = ST_HUNT;
                    else                       idx_d   = idx_q + 8'd1;
                end
            end
            default: state_d = ST_HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_HUNT;
            rd_pend_q  <= 1'b0;
            len_q      <= 8'd0;
            idx_q      <= 8'd0;
            tmo_q      <= '0;
            err_o      <= 1'b0;
            err_code_o <= ERR_NONE;
            err_cnt_o  <= 8'd0;
        end else begin
            state_q   <= state_d;
            rd_pend_q <= fifo_rd_en_o;
            len_q     <= len_d;
            idx_q     <= idx_d;
            tmo_q     <= (!active || rd_pend_q) ? '0 : tmo_q + 1'b1;
            err_o     <= err_det;
            if (err_det) begin
                err_code_o <= err_code_d;
                if (err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
            end
        end
    end

`ifdef UART_FRAME_CHKSUM_EN
    always_ff @(posedge clk) begin
        if (rst) chk_q <= 8'd0;
        else     chk_q <= chk_d;
    end
`endif

    uart_frame_buf #(.MAX_LEN(MAX_LEN), .AW(AW)) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (idx_q[AW-1:0]),
        .wdata (rx_byte),
        .raddr (idx_q[AW-1:0]),
        .rdata (buf_rdata)
    );

endmodule
